// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED playback sequencer: state encoding,
// default geometry and the thermometer pattern stored in each memory word.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_WAIT = 2'd1,
    ST_PLAY = 2'd2,
    ST_HOLD = 2'd3
  } seq_state_t;

  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 16;

  // Word for address idx: the low idx+1 bits set.
  function automatic logic [31:0] therm_pat(input logic [4:0] idx);
    logic [31:0] pat;
    pat = 32'd0;
    for (int i = 0; i < 32; i++) begin
      pat[i] = (i <= int'(idx));
    end
    return pat;
  endfunction

endpackage

// File: rtl/led_play_seq.sv
// LED playback sequencer: fills an external memory with thermometer patterns,
// then steps through it on tick while run is high, holding the final pattern.
module led_play_seq
  import led_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_fnl,
  input  logic             rst,
  input  logic             run,
  input  logic             tick,
  output logic             mem_en,
  output logic             mem_we,
  output logic [3:0]       mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] led,
  output logic             done
);

  localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

  seq_state_t  state_r;
  seq_state_t  state_s;
  logic [3:0]  ptr_r;
  logic [3:0]  ptr_s;
  logic        arm_r;
  logic        rd_v_r;
  logic        wr_s;
  logic        rd_s;
  logic [31:0] pat_s;

  // Next state, pointer and the memory operation to issue on the coming edge.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    wr_s    = 1'b0;
    rd_s    = 1'b0;
    case (state_r)
      ST_FILL: begin
        // The cycle right after reset has nothing on the bus yet; write 0 first.
        if (!arm_r) begin
          ptr_s = 4'd0;
          wr_s  = 1'b1;
        end else if (ptr_r == LAST_ADDR) begin
          ptr_s = 4'd0;
          if (run) begin
            state_s = ST_PLAY;
            rd_s    = 1'b1;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          ptr_s = ptr_r + 4'd1;
          wr_s  = 1'b1;
        end
      end
      ST_WAIT: begin
        ptr_s = 4'd0;
        if (run) begin
          state_s = ST_PLAY;
          rd_s    = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_PLAY: begin
        if (!run) begin
          state_s = ST_WAIT;
          ptr_s   = 4'd0;
        end else if (tick) begin
          if (ptr_r == LAST_ADDR) begin
            state_s = ST_HOLD;
          end else begin
            ptr_s = ptr_r + 4'd1;
            rd_s  = 1'b1;
          end
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_HOLD: begin
        if (!run) begin
          state_s = ST_WAIT;
          ptr_s   = 4'd0;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_FILL;
        ptr_s   = 4'd0;
      end
    endcase
    pat_s = therm_pat({1'b0, ptr_s});
  end

  // State, pointer and all registered outputs.
  always_ff @(posedge clk_fnl or posedge rst) begin
    if (rst) begin
      state_r   <= ST_FILL;
      ptr_r     <= 4'd0;
      arm_r     <= 1'b0;
      rd_v_r    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 4'd0;
      mem_wdata <= {WIDTH{1'b0}};
      led       <= {WIDTH{1'b0}};
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      arm_r     <= 1'b1;
      mem_en    <= wr_s | rd_s;
      mem_we    <= wr_s;
      mem_addr  <= ptr_s;
      mem_wdata <= wr_s ? WIDTH'(pat_s) : {WIDTH{1'b0}};
      done      <= (state_s == ST_HOLD);
      // rd_v_r marks the cycle in which mem_rdata carries the last read's word.
      if (state_s == ST_WAIT) begin
        rd_v_r <= 1'b0;
        led    <= {WIDTH{1'b0}};
      end else begin
        rd_v_r <= mem_en & ~mem_we;
        if (rd_v_r) begin
          led <= mem_rdata;
        end else begin
          led <= led;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_play_seq.sv
// Directed bench for led_play_seq with a synchronous external memory model.
module tb_led_play_seq;

  logic        clk_fnl;
  logic        rst;
  logic        run;
  logic        tick;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] led;
  logic        done;

  logic [15:0] mem_q [16];
  int          n_cmp;
  int          n_bad;

  led_play_seq #(.DEPTH(16), .WIDTH(16)) dut (
    .clk_fnl  (clk_fnl),
    .rst      (rst),
    .run      (run),
    .tick     (tick),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .led      (led),
    .done     (done)
  );

  initial clk_fnl = 1'b0;
  always #5 clk_fnl = ~clk_fnl;

  // One-cycle-latency synchronous memory.
  always @(posedge clk_fnl) begin
    if (mem_en && mem_we) mem_q[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem_q[mem_addr];
  end

  function automatic logic [15:0] exp_pat(input int k);
    logic [31:0] v;
    v = (32'd1 << (k + 1)) - 32'd1;
    return v[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expects 16 consecutive writes, first one visible at the next negedge.
  task automatic check_fill();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_fnl);
      chk("fill_en", {31'd0, mem_en}, 32'd1);
      chk("fill_we", {31'd0, mem_we}, 32'd1);
      chk("fill_addr", {28'd0, mem_addr}, i);
      chk("fill_data", {16'd0, mem_wdata}, {16'd0, exp_pat(i)});
    end
  endtask

  // Issue read k (by tick, or by run just raised for k=0), then see led follow.
  task automatic do_step(input int k, input bit use_tick);
    if (use_tick) tick = 1'b1;
    @(negedge clk_fnl);
    tick = 1'b0;
    chk("rd_en", {31'd0, mem_en}, 32'd1);
    chk("rd_we", {31'd0, mem_we}, 32'd0);
    chk("rd_addr", {28'd0, mem_addr}, k);
    @(negedge clk_fnl);
    chk("led_prev", {16'd0, led}, (k == 0) ? 32'd0 : {16'd0, exp_pat(k - 1)});
    @(negedge clk_fnl);
    chk("led_step", {16'd0, led}, {16'd0, exp_pat(k)});
    chk("play_done", {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    run   = 1'b0;
    tick  = 1'b0;
    repeat (3) @(negedge clk_fnl);
    chk("rst_led", {16'd0, led}, 32'd0);
    chk("rst_en", {31'd0, mem_en}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {28'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // Fill with run low, then idle in WAIT.
    rst = 1'b0;
    check_fill();
    @(negedge clk_fnl);
    chk("wait_en", {31'd0, mem_en}, 32'd0);
    chk("wait_led", {16'd0, led}, 32'd0);
    tick = 1'b1;
    @(negedge clk_fnl);
    tick = 1'b0;
    chk("wait_tick_en", {31'd0, mem_en}, 32'd0);
    @(negedge clk_fnl);
    chk("wait_tick_led", {16'd0, led}, 32'd0);

    // Full playback into HOLD.
    run = 1'b1;
    do_step(0, 1'b0);
    for (int k = 1; k < 16; k++) do_step(k, 1'b1);
    tick = 1'b1;
    @(negedge clk_fnl);
    tick = 1'b0;
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_en", {31'd0, mem_en}, 32'd0);
    chk("hold_led", {16'd0, led}, 32'h0000_FFFF);
    for (int t = 0; t < 5; t++) begin
      tick = 1'b1;
      @(negedge clk_fnl);
      tick = 1'b0;
      chk("hold_tick_en", {31'd0, mem_en}, 32'd0);
      chk("hold_tick_led", {16'd0, led}, 32'h0000_FFFF);
      chk("hold_tick_done", {31'd0, done}, 32'd1);
    end

    // Drop run from HOLD.
    run = 1'b0;
    @(negedge clk_fnl);
    chk("hold_stop_led", {16'd0, led}, 32'd0);
    chk("hold_stop_done", {31'd0, done}, 32'd0);

    // Stop after the 0x00FF step, then restart from address 0.
    run = 1'b1;
    do_step(0, 1'b0);
    for (int k = 1; k < 8; k++) do_step(k, 1'b1);
    chk("pre_stop_led", {16'd0, led}, 32'h0000_00FF);
    run = 1'b0;
    @(negedge clk_fnl);
    chk("stop_led", {16'd0, led}, 32'd0);
    chk("stop_en", {31'd0, mem_en}, 32'd0);
    @(negedge clk_fnl);
    run = 1'b1;
    do_step(0, 1'b0);

    // Tick and run falling together.
    tick = 1'b1;
    run  = 1'b0;
    @(negedge clk_fnl);
    tick = 1'b0;
    chk("coll_en", {31'd0, mem_en}, 32'd0);
    chk("coll_led", {16'd0, led}, 32'd0);
    chk("coll_done", {31'd0, done}, 32'd0);
    @(negedge clk_fnl);
    chk("coll_en2", {31'd0, mem_en}, 32'd0);

    // Reset in the middle of playback at the 0x0007 step.
    run = 1'b1;
    do_step(0, 1'b0);
    do_step(1, 1'b1);
    do_step(2, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_led", {16'd0, led}, 32'd0);
    chk("mid_rst_en", {31'd0, mem_en}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_addr", {28'd0, mem_addr}, 32'd0);
    @(negedge clk_fnl);
    rst = 1'b0;
    check_fill();
    // run is high, so the sequencer goes straight to reading address 0.
    @(negedge clk_fnl);
    chk("refill_play_en", {31'd0, mem_en}, 32'd1);
    chk("refill_play_we", {31'd0, mem_we}, 32'd0);
    chk("refill_play_addr", {28'd0, mem_addr}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
